// File: rtl/fft_out_serializer.sv
// Buffers 4-lane FFT result words captured during the DONE window and replays
// them as a 1-sample-per-cycle valid/ready stream with frame-last marking.
module fft_out_serializer #(
  parameter int DW      = 32,
  parameter int RD_LAT  = 1,
  parameter int DEPTH   = 64,
  parameter int N_WORDS = 64
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          DONE,
  input  logic [DW-1:0] DIN0,
  input  logic [DW-1:0] DIN1,
  input  logic [DW-1:0] DIN2,
  input  logic [DW-1:0] DIN3,
  output logic [DW-1:0] DOUT,
  output logic          DOUT_VALID,
  input  logic          DOUT_READY,
  output logic          DOUT_LAST,
  output logic          FRAME_RDY,
  output logic          OVERFLOW
);
  localparam int NUM_LANES = 4;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int NS = NUM_LANES * N_WORDS;
  localparam int SW = $clog2(NS);
  localparam logic [CW-1:0] FULL  = CW'(DEPTH);
  localparam logic [SW-1:0] S_END = SW'(NS - 1);

  typedef logic [NUM_LANES-1:0][DW-1:0] word_t;
  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  // DONE delay line; the oldest stage lines up with the lane data.
  logic [RD_LAT-1:0] vld_pipe_q;
  logic [RD_LAT:0]   vld_pipe;
  logic              wr_en;
  assign vld_pipe = {vld_pipe_q, DONE};
  assign wr_en    = vld_pipe[RD_LAT];

  word_t din_w;
  assign din_w = {DIN3, DIN2, DIN1, DIN0};

  word_t          mem_q [DEPTH];
  word_t          hold_q;
  state_t         state_q;
  logic [1:0]     lane_q;
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [SW-1:0]  scnt_q;
  logic           ovf_q;
  logic           nonempty, full, push, pop, hs;

  assign nonempty = (cnt_q != '0);
  assign full     = (cnt_q == FULL);
  assign push     = wr_en & ~full;
  assign hs       = (state_q == S_SHIFT) & DOUT_READY;
  // Pop either from idle or on the last lane's handshake, so a full
  // FIFO streams with no bubble between words.
  assign pop      = nonempty & ((state_q == S_IDLE) | (hs & (lane_q == 2'd3)));

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= din_w;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      vld_pipe_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      vld_pipe_q <= vld_pipe[RD_LAT-1:0];
      cnt_q      <= cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (wr_en & full) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      lane_q  <= '0;
      scnt_q  <= '0;
    end else begin
      if (pop) hold_q <= mem_q[rd_ptr_q];
      if (hs)  scnt_q <= (scnt_q == S_END) ? '0 : scnt_q + SW'(1);
      case (state_q)
        S_IDLE:
          if (nonempty) begin
            lane_q  <= '0;
            state_q <= S_SHIFT;
          end
        S_SHIFT:
          if (DOUT_READY) begin
            if (lane_q != 2'd3) lane_q <= lane_q + 2'd1;
            else if (nonempty)  lane_q <= '0;
            else                state_q <= S_IDLE;
          end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign DOUT       = hold_q[lane_q];
  assign DOUT_VALID = (state_q == S_SHIFT);
  assign DOUT_LAST  = (scnt_q == S_END) & DOUT_VALID;
  assign FRAME_RDY  = ~nonempty & (state_q == S_IDLE) & ~|vld_pipe_q & ~DONE;
  assign OVERFLOW   = ovf_q;
endmodule

// File: tb/tb_fft_out_serializer.sv
// Directed bench for fft_out_serializer: queue-level model compared every cycle,
// plus literal expectations per scenario. Three instances cover the parameter sets.
module tb_fft_out_serializer;
  logic        clk = 1'b0;
  logic        rstn, done, rdy;
  logic [1:0]  sel;
  logic [31:0] din [4];
  logic [31:0] dout_x [3];
  logic        vld_x [3], last_x [3], frdy_x [3], ovf_x [3];
  logic [31:0] o_d;
  logic        o_v, o_l, o_fr, o_ov;

  always #5 clk = ~clk;

  fft_out_serializer u_a (
    .CLK(clk), .RSTn(rstn), .DONE(done & (sel == 2'd0)),
    .DIN0(din[0]), .DIN1(din[1]), .DIN2(din[2]), .DIN3(din[3]),
    .DOUT(dout_x[0]), .DOUT_VALID(vld_x[0]), .DOUT_READY(rdy),
    .DOUT_LAST(last_x[0]), .FRAME_RDY(frdy_x[0]), .OVERFLOW(ovf_x[0]));

  fft_out_serializer #(.DEPTH(16)) u_b (
    .CLK(clk), .RSTn(rstn), .DONE(done & (sel == 2'd1)),
    .DIN0(din[0]), .DIN1(din[1]), .DIN2(din[2]), .DIN3(din[3]),
    .DOUT(dout_x[1]), .DOUT_VALID(vld_x[1]), .DOUT_READY(rdy),
    .DOUT_LAST(last_x[1]), .FRAME_RDY(frdy_x[1]), .OVERFLOW(ovf_x[1]));

  fft_out_serializer #(.RD_LAT(2)) u_c (
    .CLK(clk), .RSTn(rstn), .DONE(done & (sel == 2'd2)),
    .DIN0(din[0]), .DIN1(din[1]), .DIN2(din[2]), .DIN3(din[3]),
    .DOUT(dout_x[2]), .DOUT_VALID(vld_x[2]), .DOUT_READY(rdy),
    .DOUT_LAST(last_x[2]), .FRAME_RDY(frdy_x[2]), .OVERFLOW(ovf_x[2]));

  always_comb begin
    o_d = dout_x[0]; o_v = vld_x[0]; o_l = last_x[0]; o_fr = frdy_x[0]; o_ov = ovf_x[0];
    if (sel == 2'd1) begin
      o_d = dout_x[1]; o_v = vld_x[1]; o_l = last_x[1]; o_fr = frdy_x[1]; o_ov = ovf_x[1];
    end else if (sel == 2'd2) begin
      o_d = dout_x[2]; o_v = vld_x[2]; o_l = last_x[2]; o_fr = frdy_x[2]; o_ov = ovf_x[2];
    end
  end

  int checks = 0;
  int errors = 0;

  // Model: stored words as frame codes, the word being shifted as a sample queue.
  int          m_depth, m_lat, m_scnt, code_ctr, cyc;
  bit          m_ovf;
  int          fq [$];
  logic [31:0] hq [$];
  bit          dh [2];
  int          ch [2];

  int          acc_n, last_n, last_at, v_n, v_first, v_last, f_start;
  logic [31:0] first_val, last_val, final_val;

  function automatic logic [31:0] sval(input int code, input int k);
    return 32'(code * 4 + k);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic model_clear();
    fq.delete(); hq.delete();
    m_scnt = 0; m_ovf = 1'b0;
    dh[0] = 1'b0; dh[1] = 1'b0; ch[0] = 0; ch[1] = 0;
  endtask

  task automatic stats_clear();
    acc_n = 0; last_n = 0; last_at = -1; v_n = 0; v_first = -1; v_last = -1;
    first_val = '1; last_val = '1; final_val = '1; f_start = cyc;
  endtask

  function automatic bit model_idle();
    return fq.size() == 0 && hq.size() == 0 && !dh[0] && !dh[1];
  endfunction

  task automatic model_edge(input logic r, input bit wr, input int wc);
    int pre, c;
    logic [31:0] tmp;
    if (hq.size() > 0 && r) begin
      tmp = hq.pop_front();
      m_scnt = (m_scnt == 255) ? 0 : m_scnt + 1;
    end
    pre = fq.size();
    if (hq.size() == 0 && pre > 0) begin
      c = fq.pop_front();
      for (int k = 0; k < 4; k++) hq.push_back(sval(c, k));
    end
    if (wr) begin
      if (pre == m_depth) m_ovf = 1'b1;
      else fq.push_back(wc);
    end
  endtask

  // One clock: drive at negedge, compare just after, advance model, wait edge.
  task automatic cycle(input logic d, input logic r);
    bit wr;
    int wc;
    bit exp_v, exp_l, exp_fr;
    logic [31:0] exp_d;
    wr = dh[m_lat-1];
    wc = ch[m_lat-1];
    done = d;
    rdy  = r;
    for (int k = 0; k < 4; k++) din[k] = wr ? sval(wc, k) : (32'hDEAD0000 | 32'(k));
    #1;
    exp_v  = hq.size() > 0;
    exp_d  = exp_v ? hq[0] : '0;
    exp_l  = exp_v && (m_scnt == 255);
    exp_fr = fq.size() == 0 && !exp_v && !dh[0] && !(m_lat == 2 && dh[1]) && !d;
    checks++;
    if (o_v !== exp_v || (exp_v && o_d !== exp_d) || o_l !== exp_l ||
        o_fr !== exp_fr || o_ov !== m_ovf) begin
      errors++;
      $display("FAIL stream cyc=%0d: got v=%b d=%0h l=%b fr=%b ov=%b want v=%b d=%0h l=%b fr=%b ov=%b",
               cyc, o_v, o_d, o_l, o_fr, o_ov, exp_v, exp_d, exp_l, exp_fr, m_ovf);
    end
    if (o_v === 1'b1) begin
      v_n++;
      if (v_first < 0) v_first = cyc - f_start;
      v_last = cyc - f_start;
      if (r) begin
        if (acc_n == 0) first_val = o_d;
        if (o_l === 1'b1) begin last_n++; last_at = acc_n; last_val = o_d; end
        final_val = o_d;
        acc_n++;
      end
    end
    model_edge(r, wr, wc);
    dh[1] = dh[0]; ch[1] = ch[0];
    dh[0] = d;     ch[0] = d ? code_ctr : 0;
    if (d) code_ctr++;
    cyc++;
    @(negedge clk);
  endtask

  function automatic logic rdy_for(input int mode, input int i);
    if (mode == 1) return 1'($urandom_range(0, 1));
    if (mode == 2) return (i < 70) ? 1'b0 : 1'b1;
    return 1'b1;
  endfunction

  task automatic run_frame(input int tag, input int mode);
    int n;
    code_ctr = tag * 64;
    stats_clear();
    for (int i = 0; i < 64; i++) cycle(1'b1, rdy_for(mode, i));
    n = 0;
    while (!model_idle() && n < 2000) begin
      cycle(1'b0, rdy_for(mode, 64 + n));
      n++;
    end
    cycle(1'b0, 1'b1);
    chk("drain_within_budget", 32'(n < 2000), 32'd1);
  endtask

  initial begin
    rstn = 1'b0; done = 1'b0; rdy = 1'b0; sel = 2'd0;
    for (int k = 0; k < 4; k++) din[k] = '0;
    m_depth = 64; m_lat = 1; cyc = 0;
    model_clear(); stats_clear();
    #12;
    chk("rst_dout", o_d, 32'd0);
    chk("rst_valid", 32'(o_v), 32'd0);
    chk("rst_last", 32'(o_l), 32'd0);
    chk("rst_frame_rdy", 32'(o_fr), 32'd1);
    chk("rst_overflow", 32'(o_ov), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) cycle(1'b0, 1'b0);

    // Single frame, always ready: samples 0..255, one LAST on 255.
    run_frame(0, 0);
    chk("t1_samples", 32'(acc_n), 32'd256);
    chk("t1_valid_cycles", 32'(v_n), 32'd256);
    chk("t1_first_valid_cycle", 32'(v_first), 32'd3);
    chk("t1_contiguous", 32'(v_last - v_first), 32'd255);
    chk("t1_first_val", first_val, 32'd0);
    chk("t1_last_count", 32'(last_n), 32'd1);
    chk("t1_last_pos", 32'(last_at), 32'd255);
    chk("t1_last_val", last_val, 32'd255);

    // Random backpressure; frame tag 1 starts at 256.
    run_frame(1, 1);
    chk("t2_samples", 32'(acc_n), 32'd256);
    chk("t2_first_val", first_val, 32'd256);
    chk("t2_last_count", 32'(last_n), 32'd1);
    chk("t2_last_pos", 32'(last_at), 32'd255);
    chk("t2_last_val", last_val, 32'd511);

    // Asynchronous reset 20 words into a frame.
    code_ctr = 2 * 64;
    stats_clear();
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1);
    chk("t3_streaming_before_reset", 32'(o_v), 32'd1);
    #2;
    rstn = 1'b0;
    done = 1'b0;
    #1;
    chk("t3_rst_dout", o_d, 32'd0);
    chk("t3_rst_valid", 32'(o_v), 32'd0);
    chk("t3_rst_last", 32'(o_l), 32'd0);
    chk("t3_rst_frame_rdy", 32'(o_fr), 32'd1);
    chk("t3_rst_overflow", 32'(o_ov), 32'd0);
    model_clear();
    @(negedge clk);
    rstn = 1'b1;
    cycle(1'b0, 1'b1);
    run_frame(3, 0);
    chk("t3_first_val", first_val, 32'd768);
    chk("t3_samples", 32'(acc_n), 32'd256);
    chk("t3_last_pos", 32'(last_at), 32'd255);

    // Back-to-back frames: counter wraps, LAST once per frame.
    run_frame(4, 0);
    chk("t4a_last_count", 32'(last_n), 32'd1);
    chk("t4_frame_rdy_between", 32'(o_fr), 32'd1);
    run_frame(5, 0);
    chk("t4b_first_val", first_val, 32'd1280);
    chk("t4b_last_count", 32'(last_n), 32'd1);
    chk("t4b_last_pos", 32'(last_at), 32'd255);

    // DEPTH=16 with no READY during the window. Word 0 is already in the
    // holding register when the FIFO fills, so words 0..16 survive.
    sel = 2'd1; m_depth = 16; m_lat = 1;
    model_clear();
    cycle(1'b0, 1'b0);
    run_frame(0, 2);
    chk("t5_samples", 32'(acc_n), 32'd68);
    chk("t5_first_val", first_val, 32'd0);
    chk("t5_final_val", final_val, 32'd67);
    chk("t5_last_count", 32'(last_n), 32'd0);
    chk("t5_overflow", 32'(o_ov), 32'd1);

    // RD_LAT=2: data arrives two cycles after DONE.
    sel = 2'd2; m_depth = 64; m_lat = 2;
    model_clear();
    cycle(1'b0, 1'b0);
    run_frame(0, 0);
    chk("t6_first_valid_cycle", 32'(v_first), 32'd4);
    chk("t6_first_val", first_val, 32'd0);
    chk("t6_samples", 32'(acc_n), 32'd256);
    chk("t6_last_pos", 32'(last_at), 32'd255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
